// File: rtl/ref_clk_sel_sequencer_if.sv
// Request handshake between a divider-select requester and the sequencer.
// The requester drives code/valid; the sequencer answers with ready.
interface ref_clk_sel_sequencer_if;
  logic [2:0] sel_req;
  logic       sel_valid;
  logic       sel_ready;

  modport master (
    output sel_req,
    output sel_valid,
    input  sel_ready
  );

  modport slave (
    input  sel_req,
    input  sel_valid,
    output sel_ready
  );
endinterface

// File: rtl/ref_clk_sel_sequencer.sv
// Break-before-make sequencer for the reference clock divider tgates.
// Deselects, waits, enables the new tgate, settles, then reports lock.
module ref_clk_sel_sequencer #(
  parameter int BREAK_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  inout  wire         VDD,
  inout  wire         VSS,
  ref_clk_sel_sequencer_if.slave sel,
  output logic [4:0]  tgate_control,
  output logic [2:0]  active_sel,
  output logic        locked,
  output logic        done,
  output logic        sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    SETTLE,
    DONE
  } state_t;

  localparam logic [7:0] BRK_LD =
    8'(BREAK_CYCLES - 1);
  localparam logic [7:0] STL_LD =
    8'(SETTLE_CYCLES - 1);

  // Power pins carry no logic.
  wire unused_pwr = VDD ^ VSS;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] tg_q, tg_d;
  logic [2:0] act_q, act_d;
  logic       lk_q, lk_d;
  logic       rdy_q, rdy_d;
  logic       dn_q, dn_d;
  logic       err_q, err_d;
  logic [2:0] eff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tg_q    <= 5'b00010;
      act_q   <= 3'd1;
      lk_q    <= 1'b1;
      rdy_q   <= 1'b1;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tg_q    <= tg_d;
      act_q   <= act_d;
      lk_q    <= lk_d;
      rdy_q   <= rdy_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tg_d    = tg_q;
    act_d   = act_q;
    lk_d    = lk_q;
    rdy_d   = rdy_q;
    dn_d    = 1'b0;
    err_d   = err_q;
    eff     = sel.sel_req;
    if (sel.sel_req > 3'd4)
      eff = 3'd1;
    unique case (state_q)
      IDLE: begin
        if (sel.sel_valid) begin
          err_d = (sel.sel_req > 3'd4);
          act_d = eff;
          rdy_d = 1'b0;
          if (eff == act_q) begin
            state_d = DONE;
            dn_d    = 1'b1;
          end else begin
            state_d = BREAK;
            tg_d    = 5'b00000;
            lk_d    = 1'b0;
            cnt_d   = BRK_LD;
          end
        end
      end
      BREAK: begin
        if (cnt_q == 8'd0) begin
          state_d = SETTLE;
          tg_d    = 5'b00001 << act_q;
          cnt_d   = STL_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          dn_d    = 1'b1;
          lk_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  assign sel.sel_ready  = rdy_q;
  assign tgate_control  = tg_q;
  assign active_sel     = act_q;
  assign locked         = lk_q;
  assign done           = dn_q;
  assign sel_err        = err_q;

endmodule

// File: tb/tb_ref_clk_sel_sequencer.sv
// Bench for ref_clk_sel_sequencer: per-cycle schedule model plus
// directed and randomized request traffic.
module tb_ref_clk_sel_sequencer;
  localparam int B = 4;
  localparam int S = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;
  logic [4:0] tgate;
  logic [2:0] act;
  logic       locked;
  logic       done;
  logic       err;

  ref_clk_sel_sequencer_if sif();

  ref_clk_sel_sequencer #(
    .BREAK_CYCLES (B),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .VDD          (vdd),
    .VSS          (vss),
    .sel          (sif.slave),
    .tgate_control(tgate),
    .active_sel   (act),
    .locked       (locked),
    .done         (done),
    .sel_err      (err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Expected outputs for one cycle.
  typedef struct packed {
    logic [4:0] tg;
    logic [2:0] act;
    logic       lk;
    logic       rdy;
    logic       dn;
    logic       err;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  bit   mvalid = 0;
  bit   m_rst = 0;

  // Model: an accepted request expands into the full list of
  // per-cycle outputs it must produce; idle holds the last value.
  initial forever begin
    @(posedge clk);
    m_rst = 0;
    if (!rstn) begin
      sched.delete();
      cur = '{5'b00010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      mvalid = 1;
      m_rst = 1;
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (mvalid && cur.rdy && sif.sel_valid) begin
      logic [2:0] e;
      logic       ill;
      logic [4:0] oh;
      ill = sif.sel_req > 3'd4;
      e = ill ? 3'd1 : sif.sel_req;
      oh = 5'b00001 << e;
      if (e == cur.act) begin
        sched.push_back('{cur.tg, e, cur.lk, 1'b0, 1'b1, ill});
        sched.push_back('{cur.tg, e, cur.lk, 1'b1, 1'b0, ill});
      end else begin
        repeat (B)
          sched.push_back('{5'b0, e, 1'b0, 1'b0, 1'b0, ill});
        repeat (S)
          sched.push_back('{oh, e, 1'b0, 1'b0, 1'b0, ill});
        sched.push_back('{oh, e, 1'b1, 1'b0, 1'b1, ill});
        sched.push_back('{oh, e, 1'b1, 1'b1, 1'b0, ill});
      end
      cur = sched.pop_front();
    end
  end

  logic [4:0] prev_tg = 5'b00010;

  always @(negedge clk) begin
    if (mvalid) begin
      chk("tgate", tgate, cur.tg);
      chk("active_sel", act, cur.act);
      chk("locked", locked, cur.lk);
      chk("sel_ready", sif.sel_ready, cur.rdy);
      chk("done", done, cur.dn);
      chk("sel_err", err, cur.err);
      chk("tg_onehot0", $onehot0(tgate), 1);
      if (!m_rst)
        chk("tg_nohop", (prev_tg != 0 && tgate != 0 &&
                         tgate != prev_tg), 0);
      prev_tg = tgate;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!sif.sel_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", sif.sel_ready, 1);
  endtask

  task automatic req(input logic [2:0] c);
    sif.sel_req = c;
    sif.sel_valid = 1'b1;
    @(negedge clk);
    sif.sel_valid = 1'b0;
  endtask

  initial begin
    sif.sel_req = 3'd0;
    sif.sel_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("rst_tgate", tgate, 5'b00010);
    chk("rst_act", act, 3'd1);
    chk("rst_locked", locked, 1);
    chk("rst_ready", sif.sel_ready, 1);
    chk("rst_err", err, 0);

    req(3'd1);
    chk("same_done", done, 1);
    chk("same_tgate", tgate, 5'b00010);
    chk("same_locked", locked, 1);
    @(negedge clk);
    chk("same_done_end", done, 0);
    wait_ready();

    req(3'd4);
    for (int k = 1; k <= 21; k++) begin
      if (k == 1 || k == 4)
        chk("sw_break", tgate, 5'b00000);
      if (k == 5 || k == 20) begin
        chk("sw_settle_tg", tgate, 5'b10000);
        chk("sw_settle_lk", locked, 0);
        chk("sw_no_done", done, 0);
      end
      if (k == 21) begin
        chk("sw_done", done, 1);
        chk("sw_lock", locked, 1);
      end
      @(negedge clk);
    end
    chk("sw_done_end", done, 0);
    chk("sw_final_tg", tgate, 5'b10000);
    wait_ready();

    req(3'd0);
    wait_ready();
    chk("to0_tgate", tgate, 5'b00001);
    req(3'd6);
    chk("ill_err", err, 1);
    chk("ill_act", act, 3'd1);
    wait_ready();
    chk("ill_tgate", tgate, 5'b00010);
    req(3'd2);
    chk("legal_clr", err, 0);
    wait_ready();

    req(3'd3);
    sif.sel_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sif.sel_req = 3'($urandom_range(0, 7));
      chk("busy_ready", sif.sel_ready, 0);
      @(negedge clk);
    end
    sif.sel_valid = 1'b0;
    wait_ready();
    chk("busy_act", act, 3'd3);
    chk("busy_tgate", tgate, 5'b01000);

    req(3'd0);
    wait_ready();
    req(3'd3);
    repeat (8) @(negedge clk);
    chk("abort_settle", tgate, 5'b01000);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_tgate", tgate, 5'b00010);
    chk("abort_act", act, 3'd1);
    chk("abort_done", done, 0);
    chk("abort_locked", locked, 1);

    repeat (600) begin
      rstn = ($urandom_range(0, 79) != 0);
      sif.sel_valid = ($urandom_range(0, 2) == 0);
      sif.sel_req = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    rstn = 1'b1;
    sif.sel_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule

// File: doc/ref_clk_sel_sequencer.md
REF_CLK_SEL_SEQUENCER -- requirements
Module: ref_clk_sel_sequencer

Interface
REQ-001 The block SHALL have parameter BREAK_CYCLES, default 4: cycles with all tgates off between deselect and select; legal range 1..255.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16: cycles after the new tgate is enabled before lock is declared; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: sequencer clock, rising-edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have ports VDD and VSS, inout, 1 bit each: local power, with no logical function.
REQ-006 The block SHALL have port sel_req, input, 3 bits: requested divider code (0=512, 1=256, 2=128, 3=64, 4=32).
REQ-007 The block SHALL have port sel_valid, input, 1 bit: request valid.
REQ-008 The block SHALL have port sel_ready, output, 1 bit: request can be accepted.
REQ-009 The block SHALL have port tgate_control, output, 5 bits: one-hot tgate enables {32,64,128,256,512}, where bit0 is 512.
REQ-010 The block SHALL have port active_sel, output, 3 bits: code currently driven or being switched to.
REQ-011 The block SHALL have port locked, output, 1 bit: selection stable and settled.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at completion of each accepted request.
REQ-013 The block SHALL have port sel_err, output, 1 bit: last accepted request carried an illegal code (5..7).

Function
REQ-014 The block SHALL use four states: IDLE, BREAK, SETTLE and DONE, with all outputs registered.
REQ-015 sel_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with sel_valid=1 and sel_ready=1.
REQ-016 On acceptance, an illegal code (5..7) SHALL be treated as code 1, and sel_err SHALL be set; any legal accepted code SHALL clear sel_err.
REQ-017 On acceptance, active_sel SHALL update to the effective code in the next cycle.
REQ-018 If the effective code equals the current active_sel, the block SHALL go IDLE->DONE; tgate_control and locked SHALL stay unchanged.
REQ-019 Otherwise the block SHALL go IDLE->BREAK: tgate_control=5'b00000 and locked=0 from the next cycle, for exactly BREAK_CYCLES cycles.
REQ-020 BREAK->SETTLE: tgate_control SHALL equal the one-hot of the effective code, and locked SHALL remain 0, for exactly SETTLE_CYCLES cycles.
REQ-021 SETTLE->DONE: done=1 for exactly one cycle, locked=1, and sel_ready=0.
REQ-022 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-023 At most one tgate_control bit SHALL be high in every cycle; tgate_control SHALL never go directly from one nonzero value to a different nonzero value.
REQ-024 sel_req and sel_valid SHALL be ignored outside IDLE; requests are not queued.
REQ-025 The BREAK and SETTLE counters SHALL be 8 bits, load (parameter-1) on state entry, decrement to 0 and then advance, with no wrap.
REQ-026 Total latency from acceptance edge to done=1 SHALL be BREAK_CYCLES+SETTLE_CYCLES+1 cycles for a change and 1 cycle for a same-code request.
REQ-027 A request at the same edge that DONE->IDLE occurs SHALL NOT be accepted; the earliest acceptance is the first IDLE cycle.

Reset
REQ-028 With rstn=0 at a rising edge, the block SHALL enter IDLE with: tgate_control=5'b00010 (256 division), active_sel=3'd1, locked=1, sel_ready=1, done=0, sel_err=0, and counters=0.
REQ-029 Reset asserted mid-BREAK or mid-SETTLE SHALL abort the switch with no done pulse, and outputs SHALL take REQ-028 values on the next cycle.
REQ-030 rstn SHALL take priority over every other input.

Verification
REQ-031 Post-reset check: after rstn low for 2 cycles then high -> tgate_control=00010, active_sel=1, locked=1, sel_ready=1.
REQ-032 Switch check with defaults: request code 4 -> tgate=00000 for 4 cycles, then 10000 for 16 cycles with locked=0, done pulse at acceptance+21, locked=1 thereafter.
REQ-033 Same-code check: request code 1 after reset -> tgate stays 00010, locked stays 1, done pulse at acceptance+1.
REQ-034 Illegal-code check: from active code 0, request code 6 -> sel_err=1, active_sel=1, sequence ends at tgate=00010; a following legal request clears sel_err.
REQ-035 Reset-abort check: rstn low during SETTLE of a switch to code 3 -> no done pulse, tgate=00010 and active_sel=1 next cycle.
REQ-036 Busy check: sel_valid held high with changing sel_req during BREAK -> request ignored, sel_ready=0, the original target completes; a one-hot/zero assertion on tgate_control passes for all scenarios.
